// File: rtl/dsp_dma_bus_responder.sv
// dsp_dma_bus_responder
//   Bus-side responder for the DSP DMA memory-cycle sequencer. Raises a hold
//   request to the CPU when the DSP asks for the bus, acknowledges the DSP once
//   the CPU has let go, stretches DMA accesses to slow memory with WAIT, and
//   decodes the memory output/write strobes for each DMA cycle.
//
// Ports
//   CLK       in   system clock, all state on the rising edge
//   RESET     in   asynchronous reset, active high
//   DSPBRQ    in   DSP DMA bus request (level, held for the whole tenure)
//   CPUHLDA   in   CPU hold acknowledge
//   MREQL     in   DMA memory request, active low, one cycle per access
//   ST23L     in   DMA sequencer in states 2/3, active low
//   DMAWRITE  in   1 = current access writes memory, 0 = reads
//   MEMSLOW   in   current access targets slow memory
//   CPUHOLD   out  hold request to the CPU
//   DSPBAK    out  bus acknowledge to the DMA sequencer
//   DSPBAKL   out  inverse of DSPBAK
//   WAIT      out  stretch the current DMA memory cycle
//   MEMOEL    out  memory output enable, active low
//   MEMWEL    out  memory write enable, active low
//   PROTERR   out  sticky protocol-error flag
module dsp_dma_bus_responder #(
    parameter int SLOW_WAITS = 2,
    parameter int CNT_W      = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic DSPBRQ,
    input  logic CPUHLDA,
    input  logic MREQL,
    input  logic ST23L,
    input  logic DMAWRITE,
    input  logic MEMSLOW,
    output logic CPUHOLD,
    output logic DSPBAK,
    output logic DSPBAKL,
    output logic WAIT,
    output logic MEMOEL,
    output logic MEMWEL,
    output logic PROTERR
);

    localparam logic [CNT_W-1:0] SLOW_CNT = CNT_W'(SLOW_WAITS);

    typedef enum logic [2:0] {
        IDLE,
        HOLDREQ,
        GRANTED,
        ACCESS,
        RELEASE
    } state_t;

    state_t           state, state_nxt;
    logic             cpuhold, cpuhold_nxt;
    logic             dspbak, dspbak_nxt;
    logic             wait_q, wait_nxt;
    logic             proterr, proterr_nxt;
    logic [CNT_W-1:0] count, count_nxt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            cpuhold <= 1'b0;
            dspbak  <= 1'b0;
            wait_q  <= 1'b0;
            proterr <= 1'b0;
            count   <= '0;
        end else begin
            state   <= state_nxt;
            cpuhold <= cpuhold_nxt;
            dspbak  <= dspbak_nxt;
            wait_q  <= wait_nxt;
            proterr <= proterr_nxt;
            count   <= count_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cpuhold_nxt = cpuhold;
        dspbak_nxt  = dspbak;
        wait_nxt    = wait_q;
        proterr_nxt = proterr;
        count_nxt   = count;

        case (state)
            IDLE: begin
                if (!MREQL) proterr_nxt = 1'b1;
                if (DSPBRQ) begin
                    state_nxt   = HOLDREQ;
                    cpuhold_nxt = 1'b1;
                end
            end

            HOLDREQ: begin
                if (!MREQL) proterr_nxt = 1'b1;
                // A withdrawn request wins over a grant arriving on the same edge.
                if (!DSPBRQ) begin
                    state_nxt   = IDLE;
                    cpuhold_nxt = 1'b0;
                end else if (CPUHLDA) begin
                    state_nxt  = GRANTED;
                    dspbak_nxt = 1'b1;
                end
            end

            GRANTED: begin
                if (!CPUHLDA) proterr_nxt = 1'b1;
                // A new access takes priority; the release is picked up afterwards.
                if (!MREQL) begin
                    state_nxt = ACCESS;
                    count_nxt = MEMSLOW ? SLOW_CNT : '0;
                    wait_nxt  = MEMSLOW && (SLOW_CNT != '0);
                end else if (!DSPBRQ && ST23L) begin
                    state_nxt  = RELEASE;
                    dspbak_nxt = 1'b0;
                end
            end

            ACCESS: begin
                if (!CPUHLDA) proterr_nxt = 1'b1;
                if (!MREQL)   proterr_nxt = 1'b1;
                if (count != '0) begin
                    // WAIT stays up while the count being left behind is non-zero,
                    // so it is high for exactly the loaded number of cycles.
                    count_nxt = count - 1'b1;
                    wait_nxt  = (count != CNT_W'(1));
                end else if (ST23L) begin
                    if (DSPBRQ) begin
                        state_nxt = GRANTED;
                    end else begin
                        state_nxt  = RELEASE;
                        dspbak_nxt = 1'b0;
                    end
                end
            end

            RELEASE: begin
                if (!MREQL) proterr_nxt = 1'b1;
                state_nxt   = IDLE;
                cpuhold_nxt = 1'b0;
            end

            default: begin
                state_nxt   = IDLE;
                cpuhold_nxt = 1'b0;
                dspbak_nxt  = 1'b0;
                wait_nxt    = 1'b0;
                count_nxt   = '0;
            end
        endcase
    end

    assign CPUHOLD = cpuhold;
    assign DSPBAK  = dspbak;
    assign DSPBAKL = ~dspbak;
    assign WAIT    = wait_q;
    assign PROTERR = proterr;

    // Strobes follow the sequencer directly so they track ST23L without delay;
    // gating with the registered acknowledge keeps them idle outside a tenure.
    assign MEMOEL = ~(dspbak & ~ST23L & ~DMAWRITE);
    assign MEMWEL = ~(dspbak & ~ST23L & DMAWRITE);

endmodule

// File: tb/tb_dsp_dma_bus_responder.sv
module tb_dsp_dma_bus_responder;

    localparam int SLOW_WAITS = 2;
    localparam int CNT_W      = 4;

    logic CLK      = 1'b0;
    logic RESET    = 1'b0;
    logic DSPBRQ   = 1'b0;
    logic CPUHLDA  = 1'b0;
    logic MREQL    = 1'b1;
    logic ST23L    = 1'b1;
    logic DMAWRITE = 1'b0;
    logic MEMSLOW  = 1'b0;
    logic CPUHOLD, DSPBAK, DSPBAKL, WAIT, MEMOEL, MEMWEL, PROTERR;

    int n_checks = 0;
    int n_fail   = 0;

    dsp_dma_bus_responder #(
        .SLOW_WAITS(SLOW_WAITS),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .DSPBRQ  (DSPBRQ),
        .CPUHLDA (CPUHLDA),
        .MREQL   (MREQL),
        .ST23L   (ST23L),
        .DMAWRITE(DMAWRITE),
        .MEMSLOW (MEMSLOW),
        .CPUHOLD (CPUHOLD),
        .DSPBAK  (DSPBAK),
        .DSPBAKL (DSPBAKL),
        .WAIT    (WAIT),
        .MEMOEL  (MEMOEL),
        .MEMWEL  (MEMWEL),
        .PROTERR (PROTERR)
    );

    always #5 CLK = ~CLK;

    // Reference model: tenure described by flags (holding, acknowledged,
    // in an access, releasing) and the number of wait cycles still owed.
    logic m_hold = 1'b0;
    logic m_bak  = 1'b0;
    logic m_acc  = 1'b0;
    logic m_rel  = 1'b0;
    logic m_perr = 1'b0;
    int   m_waits = 0;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_hold  <= 1'b0;
            m_bak   <= 1'b0;
            m_acc   <= 1'b0;
            m_rel   <= 1'b0;
            m_perr  <= 1'b0;
            m_waits <= 0;
        end else if (!m_hold) begin
            if (!MREQL) m_perr <= 1'b1;
            if (DSPBRQ) m_hold <= 1'b1;
        end else if (m_rel) begin
            if (!MREQL) m_perr <= 1'b1;
            m_rel  <= 1'b0;
            m_hold <= 1'b0;
        end else if (!m_bak) begin
            if (!MREQL) m_perr <= 1'b1;
            if (!DSPBRQ) m_hold <= 1'b0;
            else if (CPUHLDA) m_bak <= 1'b1;
        end else if (!m_acc) begin
            if (!CPUHLDA) m_perr <= 1'b1;
            if (!MREQL) begin
                m_acc   <= 1'b1;
                m_waits <= MEMSLOW ? SLOW_WAITS : 0;
            end else if (!DSPBRQ && ST23L) begin
                m_bak <= 1'b0;
                m_rel <= 1'b1;
            end
        end else begin
            if (!CPUHLDA) m_perr <= 1'b1;
            if (!MREQL)   m_perr <= 1'b1;
            if (m_waits > 0) begin
                m_waits <= m_waits - 1;
            end else if (ST23L) begin
                m_acc <= 1'b0;
                if (!DSPBRQ) begin
                    m_bak <= 1'b0;
                    m_rel <= 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        logic [6:0] exp_v, act_v;
        exp_v = {m_hold, m_bak, !m_bak, (m_acc && (m_waits > 0)),
                 !(m_bak && !ST23L && !DMAWRITE),
                 !(m_bak && !ST23L && DMAWRITE), m_perr};
        act_v = {CPUHOLD, DSPBAK, DSPBAKL, WAIT, MEMOEL, MEMWEL, PROTERR};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t {hold,bak,bakl,wait,oel,wel,perr} got %b expected %b",
                     $time, act_v, exp_v);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic idle_inputs();
        DSPBRQ   = 1'b0;
        CPUHLDA  = 1'b0;
        MREQL    = 1'b1;
        ST23L    = 1'b1;
        DMAWRITE = 1'b0;
        MEMSLOW  = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        idle_inputs();
        tick();
        tick();
        RESET = 1'b0;
        #1;
        chk("reset_cpuhold", CPUHOLD, 1'b0);
        chk("reset_dspbak",  DSPBAK,  1'b0);
        chk("reset_dspbakl", DSPBAKL, 1'b1);
        chk("reset_wait",    WAIT,    1'b0);
        chk("reset_proterr", PROTERR, 1'b0);
        chk("reset_memoel",  MEMOEL,  1'b1);
        chk("reset_memwel",  MEMWEL,  1'b1);
    endtask

    task automatic drive_random(input bit viol);
        if ($urandom_range(11) == 0) DSPBRQ = ~DSPBRQ;
        if ($urandom_range(2) != 0) CPUHLDA = m_hold;
        if (viol && ($urandom_range(39) == 0)) CPUHLDA = ~CPUHLDA;
        if (m_bak && !m_acc) MREQL = ($urandom_range(3) != 0);
        else                 MREQL = !(viol && ($urandom_range(29) == 0));
        if (!MREQL)     ST23L = 1'b0;
        else if (m_acc) ST23L = ($urandom_range(2) == 0);
        else            ST23L = ($urandom_range(3) != 0);
        DMAWRITE = ($urandom_range(1) != 0);
        MEMSLOW  = ($urandom_range(1) != 0);
    endtask

    initial begin
        #2;
        do_reset();

        // Bus request to acknowledge latency.
        DSPBRQ = 1'b1;                       // c0
        tick(); #1;                          // c1
        chk("t1_cpuhold_c1", CPUHOLD, 1'b1);
        chk("t1_dspbak_c1",  DSPBAK,  1'b0);
        tick();                              // c2
        CPUHLDA = 1'b1;
        #1;
        chk("t1_dspbak_c2",  DSPBAK,  1'b0);
        tick(); #1;                          // c3
        chk("t1_dspbak_c3",  DSPBAK,  1'b1);
        chk("t1_dspbakl_c3", DSPBAKL, 1'b0);

        // Slow read: two wait cycles after the request.
        MEMSLOW = 1'b1; DMAWRITE = 1'b0; MREQL = 1'b0; ST23L = 1'b0;   // cN
        #1;
        chk("t2_memoel_n",  MEMOEL, 1'b0);
        chk("t2_wait_n",    WAIT,   1'b0);
        tick();
        MREQL = 1'b1;
        #1;
        chk("t2_wait_n1",   WAIT,   1'b1);
        chk("t2_memoel_n1", MEMOEL, 1'b0);
        chk("t2_memwel_n1", MEMWEL, 1'b1);
        tick(); #1;
        chk("t2_wait_n2",   WAIT,   1'b1);
        tick(); #1;
        chk("t2_wait_n3",   WAIT,   1'b0);
        chk("t2_memoel_n3", MEMOEL, 1'b0);
        tick();
        ST23L = 1'b1;
        #1;
        chk("t2_memoel_end", MEMOEL, 1'b1);
        tick();

        // Fast write: no WAIT, write strobe tracks ST23L.
        MEMSLOW = 1'b0; DMAWRITE = 1'b1; MREQL = 1'b0; ST23L = 1'b0;
        #1;
        chk("t3_memwel_n", MEMWEL, 1'b0);
        chk("t3_memoel_n", MEMOEL, 1'b1);
        tick();
        MREQL = 1'b1;
        #1;
        chk("t3_wait_n1",   WAIT,   1'b0);
        chk("t3_memwel_n1", MEMWEL, 1'b0);
        tick();
        ST23L = 1'b1;
        #1;
        chk("t3_memwel_end", MEMWEL, 1'b1);
        chk("t3_wait_end",   WAIT,   1'b0);
        tick(); #1;
        chk("t3_dspbak_after", DSPBAK, 1'b1);

        // Request withdrawn during the wait states.
        MEMSLOW = 1'b1; DMAWRITE = 1'b0; MREQL = 1'b0; ST23L = 1'b0;
        tick();
        MREQL = 1'b1; DSPBRQ = 1'b0;
        #1;
        chk("t4_wait_n1", WAIT, 1'b1);
        tick(); #1;
        chk("t4_wait_n2",   WAIT,   1'b1);
        chk("t4_dspbak_n2", DSPBAK, 1'b1);
        tick();
        ST23L = 1'b1;
        #1;
        chk("t4_wait_n3",   WAIT,   1'b0);
        chk("t4_dspbak_n3", DSPBAK, 1'b1);
        tick(); #1;
        chk("t4_dspbak_rel",  DSPBAK,  1'b0);
        chk("t4_cpuhold_rel", CPUHOLD, 1'b1);
        tick();
        CPUHLDA = 1'b0;
        #1;
        chk("t4_cpuhold_idle", CPUHOLD, 1'b0);
        chk("t4_proterr",      PROTERR, 1'b0);

        // Withdrawal before grant, then a stray request in IDLE.
        DSPBRQ = 1'b1;
        tick();
        DSPBRQ = 1'b0;
        #1;
        chk("t5_cpuhold_req", CPUHOLD, 1'b1);
        tick();
        MREQL = 1'b0;
        #1;
        chk("t5_cpuhold_drop", CPUHOLD, 1'b0);
        chk("t5_dspbak",       DSPBAK,  1'b0);
        tick();
        MREQL = 1'b1;
        #1;
        chk("t5_proterr", PROTERR, 1'b1);
        chk("t5_wait",    WAIT,    1'b0);

        // Asynchronous reset in the middle of a wait state.
        DSPBRQ = 1'b1;
        tick();
        CPUHLDA = 1'b1;
        tick();
        MREQL = 1'b0; ST23L = 1'b0; MEMSLOW = 1'b1; DMAWRITE = 1'b0;
        tick();
        MREQL = 1'b1;
        #1;
        chk("t6_wait_pre", WAIT, 1'b1);
        RESET = 1'b1;
        #1;
        chk("t6_cpuhold", CPUHOLD, 1'b0);
        chk("t6_dspbak",  DSPBAK,  1'b0);
        chk("t6_dspbakl", DSPBAKL, 1'b1);
        chk("t6_wait",    WAIT,    1'b0);
        chk("t6_proterr", PROTERR, 1'b0);
        chk("t6_memoel",  MEMOEL,  1'b1);
        chk("t6_memwel",  MEMWEL,  1'b1);
        tick();
        RESET = 1'b0;
        idle_inputs();
        DSPBRQ = 1'b1;
        tick(); #1;
        chk("t6_restart_cpuhold", CPUHOLD, 1'b1);
        chk("t6_restart_dspbak",  DSPBAK,  1'b0);

        // Randomized traffic, alternating clean and protocol-violating segments.
        for (int s = 0; s < 6; s++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                drive_random(s[0]);
                tick();
            end
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
